hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/pend_counter.sv | 28 ++
 rtl/hazard_scoreboard.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard: instruction classes,
// FSM states and sizing helpers.
package hazard_scoreboard_pkg;

  localparam int REG_LOGSIZE_DEF = 5;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_OTHER  = 2'd3
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STALL_RAW = 2'd1,
    ST_STALL_MEM = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..v, never less than one.
  function automatic int width_for(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Per-register pending countdown: load on producer issue, set on late load
// completion, freeze while an outstanding load owns it, else count down to 0.
module pend_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         set,
  input  logic [W-1:0] set_val,
  input  logic         hold,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (set) begin
      count <= set_val;
    end else if (!hold && count != '0) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: per-register countdowns, stall/bubble
// generation, optional variable-latency load tracking and a stall statistic.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_LOGSIZE = REG_LOGSIZE_DEF,
  parameter int ALU_LAT     = 0,
  parameter int LOAD_LAT    = 1,
  parameter int BR_EXTRA    = 1,
  parameter int VAR_MEM     = 0,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic [1:0]             dec_class,
  input  logic [REG_LOGSIZE-1:0] rs1,
  input  logic [REG_LOGSIZE-1:0] rs2,
  input  logic                   rs1_used,
  input  logic                   rs2_used,
  input  logic [REG_LOGSIZE-1:0] rd,
  input  logic                   rd_we,
  input  logic                   mem_ready,
  input  logic                   flush,
  output logic                   pc_en,
  output logic                   fd_en,
  output logic                   de_bubble,
  output logic                   issue,
  output logic [1:0]             state_o,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int NREG     = 2 ** REG_LOGSIZE;
  localparam int PEND_MAX = max_int(LOAD_LAT, ALU_LAT) + BR_EXTRA;
  localparam int PW       = width_for(PEND_MAX);

  // Producers start at lat+BR_EXTRA so branches (compare in decode) see the
  // extra wait while ordinary consumers only compare against BR_EXTRA.
  localparam logic [PW-1:0] BR_V   = PW'(BR_EXTRA);
  localparam logic [PW-1:0] ALU_V  = PW'(ALU_LAT + BR_EXTRA);
  localparam logic [PW-1:0] LOAD_V = PW'(LOAD_LAT + BR_EXTRA);
  localparam logic [PW-1:0] MAX_V  = PW'(PEND_MAX);
  localparam logic          VM     = (VAR_MEM != 0);

  logic [NREG-1:0][PW-1:0] pend;
  logic                    ld_busy;
  logic [REG_LOGSIZE-1:0]  ld_rd;
  state_e                  state;

  logic                    is_branch;
  logic                    is_load;
  logic [PW-1:0]           thr;
  logic                    blk1;
  logic                    blk2;
  logic                    hazard;
  logic                    mem_stall;
  logic                    stall;
  logic                    mem_owned;
  logic                    wr_en;
  logic [PW-1:0]           wr_val;
  logic                    ld_start;
  logic                    ld_done;

  assign pend[0] = '0;

  // Hazard detection; reset masks the stored state so outputs look cleared.
  always_comb begin
    is_branch = (dec_class == CLS_BRANCH);
    is_load   = (dec_class == CLS_LOAD);
    thr       = is_branch ? '0 : BR_V;
    blk1      = rs1_used && (pend[rs1] > thr);
    blk2      = rs2_used && (pend[rs2] > thr);
    hazard    = !rst && dec_valid && (blk1 || blk2);
    mem_stall = !rst && VM && dec_valid && is_load && ld_busy;
    stall     = hazard || mem_stall;
    mem_owned = ld_busy && (mem_stall ||
                            (blk1 && rs1 == ld_rd) ||
                            (blk2 && rs2 == ld_rd));
  end

  assign issue     = dec_valid && !stall && !flush;
  assign pc_en     = !stall;
  assign fd_en     = !stall;
  assign de_bubble = stall || flush;
  assign state_o   = state;

  always_comb begin
    wr_val = BR_V;
    case (dec_class)
      CLS_ALU:  wr_val = ALU_V;
      CLS_LOAD: wr_val = VM ? MAX_V : LOAD_V;
      default:  wr_val = BR_V;
    endcase
  end

  assign wr_en    = issue && rd_we && (rd != '0);
  assign ld_start = issue && VM && is_load;
  assign ld_done  = VM && mem_ready && ld_busy;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    localparam logic [REG_LOGSIZE-1:0] IDX = REG_LOGSIZE'(r);
    pend_counter #(
      .W(PW)
    ) u_pend (
      .clk      (clk),
      .rst      (rst),
      .load     (wr_en && rd == IDX),
      .load_val (wr_val),
      .set      (ld_done && ld_rd == IDX),
      .set_val  (BR_V),
      .hold     (ld_busy && ld_rd == IDX),
      .count    (pend[r])
    );
  end

  // Control state: outstanding load, FSM and stall statistic.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_busy   <= 1'b0;
      ld_rd     <= '0;
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      if (ld_start) begin
        ld_busy <= 1'b1;
        ld_rd   <= rd;
      end else if (ld_done) begin
        ld_busy <= 1'b0;
      end

      if (flush || !stall) begin
        state <= ST_RUN;
      end else if (mem_owned) begin
        state <= ST_STALL_MEM;
      end else begin
        state <= ST_STALL_RAW;
      end

      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
